// File: rtl/sram_controller.sv
// Data-memory port that serves 32-bit word requests as two 16-bit accesses
// (low half, then high half) on an external asynchronous SRAM.
module sram_controller #(
    parameter int unsigned BASE_ADDR     = 1024,
    parameter int unsigned SRAM_ADDR_W   = 18,
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdEn,
    input  logic                   wrEn,
    input  logic [31:0]            address,
    input  logic [31:0]            writeData,
    output logic [31:0]            readData,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sramAddr,
    output logic [15:0]            sramDataOut,
    input  logic [15:0]            sramDataIn,
    output logic                   sramDataOE,
    output logic                   sramWE_N
);

    localparam int unsigned WORD_W = SRAM_ADDR_W - 1;
    localparam int unsigned CNT_W  = 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic              wr;
        logic [WORD_W-1:0] word;
        logic [31:0]       wdata;
    } req_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    req_t                   req_q, req_d;
    logic [31:0]            rdata_d;
    logic [SRAM_ADDR_W-1:0] addr_d;
    logic [15:0]            dout_d;
    logic                   oe_d;
    logic                   we_n_d;
    logic                   req_c;
    logic                   last_c;

    // State, latched request and registered SRAM bus
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_q       <= '0;
            readData    <= '0;
            sramAddr    <= '0;
            sramDataOut <= '0;
            sramDataOE  <= 1'b0;
            sramWE_N    <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            readData    <= rdata_d;
            sramAddr    <= addr_d;
            sramDataOut <= dout_d;
            sramDataOE  <= oe_d;
            sramWE_N    <= we_n_d;
        end
    end

    // Next state, request latch and read-data capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        rdata_d = readData;
        ready   = 1'b0;
        req_c   = rdEn | wrEn;
        last_c  = (cnt_q == CNT_LAST);

        unique case (state_q)
            IDLE: begin
                ready = ~req_c;
                if (req_c) begin
                    state_d     = LO;
                    cnt_d       = '0;
                    req_d.wr    = wrEn;
                    req_d.word  = WORD_W'((address - BASE_ADDR) >> 2);
                    req_d.wdata = writeData;
                end
            end
            LO: begin
                if (last_c) begin
                    state_d = HI;
                    cnt_d   = '0;
                    if (!req_q.wr) begin
                        rdata_d[15:0] = sramDataIn;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HI: begin
                if (last_c) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    if (!req_q.wr) begin
                        rdata_d[31:16] = sramDataIn;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                ready   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // SRAM bus values for the upcoming state, so the pins never follow request inputs
    always_comb begin
        addr_d = '0;
        dout_d = '0;
        oe_d   = 1'b0;
        we_n_d = 1'b1;
        if ((state_d == LO) || (state_d == HI)) begin
            addr_d = {req_d.word, (state_d == HI)};
            if (req_d.wr) begin
                we_n_d = 1'b0;
                oe_d   = 1'b1;
                dout_d = (state_d == HI) ? req_d.wdata[31:16] : req_d.wdata[15:0];
            end
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: SRAM device model, transaction-timeline reference
// model, per-cycle output comparison, directed and randomized traffic.
module tb_sram_controller;

    localparam int A = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdEn = 1'b0;
    logic        wrEn = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] writeData = '0;
    logic [31:0] readData;
    logic        ready;
    logic [17:0] sramAddr;
    logic [15:0] sramDataOut;
    logic [15:0] sramDataIn;
    logic        sramDataOE;
    logic        sramWE_N;

    logic init_mem = 1'b1;
    logic chk_en = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    sram_controller #(
        .BASE_ADDR    (1024),
        .SRAM_ADDR_W  (18),
        .ACCESS_CYCLES(A)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rdEn       (rdEn),
        .wrEn       (wrEn),
        .address    (address),
        .writeData  (writeData),
        .readData   (readData),
        .ready      (ready),
        .sramAddr   (sramAddr),
        .sramDataOut(sramDataOut),
        .sramDataIn (sramDataIn),
        .sramDataOE (sramDataOE),
        .sramWE_N   (sramWE_N)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // External SRAM: writes commit while WE_N is low, reads are asynchronous
    logic [15:0] sram_mem [0:1023];
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 1024; i++) sram_mem[i] <= 16'h0;
        end else if (!sramWE_N) begin
            sram_mem[sramAddr[9:0]] <= sramDataOut;
        end
    end
    always_comb sramDataIn = sram_mem[sramAddr[9:0]];

    // Reference: ph counts edges since acceptance; -1 = free, 1..A low half,
    // A+1..2A high half, 2A+1 = the completion cycle
    int          ph;
    logic        m_wr;
    logic [16:0] m_word;
    logic [31:0] m_wd;
    logic [31:0] m_rdata;
    logic [15:0] ref_mem [0:1023];

    always @(posedge clk or posedge rst) begin
        if (init_mem) begin
            for (int i = 0; i < 1024; i++) ref_mem[i] <= 16'h0;
        end else if (rst) begin
            ph      <= -1;
            m_wr    <= 1'b0;
            m_word  <= '0;
            m_wd    <= '0;
            m_rdata <= '0;
        end else if (ph == -1) begin
            if (rdEn || wrEn) begin
                ph     <= 1;
                m_wr   <= wrEn;
                m_word <= 17'((address - 32'd1024) >> 2);
                m_wd   <= writeData;
            end
        end else if (ph == 2 * A + 1) begin
            ph <= -1;
        end else begin
            if (m_wr) begin
                ref_mem[{m_word[8:0], 1'(ph > A)}] <= (ph > A) ? m_wd[31:16] : m_wd[15:0];
            end else if (ph == A) begin
                m_rdata[15:0] <= ref_mem[{m_word[8:0], 1'b0}];
            end else if (ph == 2 * A) begin
                m_rdata[31:16] <= ref_mem[{m_word[8:0], 1'b1}];
            end
            ph <= ph + 1;
        end
    end

    // Per-cycle comparison of every DUT output against the reference
    always @(negedge clk) begin : cmp
        logic        in_acc;
        logic        hi;
        logic        exp_rdy;
        logic [17:0] ea;
        logic [15:0] ed;
        if (chk_en) begin
            in_acc  = (ph >= 1) && (ph <= 2 * A);
            hi      = (ph > A);
            exp_rdy = (ph == -1) ? !(rdEn || wrEn) : (ph == 2 * A + 1);
            ea      = in_acc ? {m_word, hi} : 18'h0;
            ed      = hi ? m_wd[31:16] : m_wd[15:0];
            chk("ready", 32'(ready), 32'(exp_rdy));
            chk("sramWE_N", 32'(sramWE_N), 32'(!(in_acc && m_wr)));
            chk("sramDataOE", 32'(sramDataOE), 32'(in_acc && m_wr));
            chk("sramAddr", 32'(sramAddr), 32'(ea));
            if (!in_acc) chk("sramDataOut_idle", 32'(sramDataOut), 32'h0);
            else if (m_wr) chk("sramDataOut", 32'(sramDataOut), 32'(ed));
            chk("readData", readData, m_rdata);
        end
    end

    task automatic req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input bit hold, input bit noise,
                       output int stalls, output int we_low, output logic [17:0] first_addr);
        bit done;
        @(posedge clk);
        #1;
        rdEn = rd; wrEn = wr; address = a; writeData = d;
        stalls = 0; we_low = 0; first_addr = '0; done = 0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if (ready) begin
                done = 1;
            end else begin
                stalls++;
                if (!sramWE_N) we_low++;
                if (stalls == 2) first_addr = sramAddr;
                if (noise && stalls >= 2) begin
                    #1;
                    address = $urandom;
                    writeData = $urandom;
                end
            end
        end
        if (!done) chk("req_timeout", 32'd0, 32'd1);
        if (!hold) begin
            @(posedge clk);
            #1;
            rdEn = 1'b0; wrEn = 1'b0;
        end
    endtask

    task automatic abort_req(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] d, input int k);
        @(posedge clk);
        #1;
        rdEn = rd; wrEn = wr; address = a; writeData = d;
        repeat (k) @(negedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_ready", 32'(ready), 32'(!(rd || wr)));
        chk("rst_we_n", 32'(sramWE_N), 32'd1);
        chk("rst_oe", 32'(sramDataOE), 32'd0);
        chk("rst_addr", 32'(sramAddr), 32'd0);
        chk("rst_rdata", readData, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0; rdEn = 1'b0; wrEn = 1'b0;
    endtask

    initial begin : stim
        int          st;
        int          wl;
        logic [17:0] fa;
        int          diffs;
        int          op;
        bit          hold;
        logic [31:0] a;

        @(posedge clk);
        #1;
        init_mem = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_we_n", 32'(sramWE_N), 32'd1);
        chk("reset_oe", 32'(sramDataOE), 32'd0);
        chk("reset_rdata", readData, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        req(1'b0, 1'b1, 32'd1024, 32'h5555_5555, 0, 0, st, wl, fa);
        chk("t1_stall", 32'(st), 32'd5);
        chk("t1_we_low", 32'(wl), 32'd4);
        chk("t1_addr", 32'(fa), 32'd0);
        chk("t1_hw0", 32'(sram_mem[0]), 32'h5555);
        chk("t1_hw1", 32'(sram_mem[1]), 32'h5555);
        chk("t1_we_after", 32'(sramWE_N), 32'd1);
        chk("t1_oe_after", 32'(sramDataOE), 32'd0);

        req(1'b0, 1'b1, 32'd1030, 32'hAAAA_AAAA, 0, 0, st, wl, fa);
        chk("t2_addr", 32'(fa), 32'd2);
        chk("t2_hw2", 32'(sram_mem[2]), 32'hAAAA);
        chk("t2_hw3", 32'(sram_mem[3]), 32'hAAAA);
        req(1'b1, 1'b0, 32'd1028, 32'h0, 0, 0, st, wl, fa);
        chk("t2_read", readData, 32'hAAAA_AAAA);
        chk("t2_read_stall", 32'(st), 32'd5);
        chk("t2_read_we_low", 32'(wl), 32'd0);

        req(1'b0, 1'b1, 32'd1032, 32'hFFFF_0000, 0, 0, st, wl, fa);
        req(1'b1, 1'b0, 32'd1033, 32'h0, 0, 0, st, wl, fa);
        chk("t3_addr", 32'(fa), 32'd4);
        chk("t3_read", readData, 32'hFFFF_0000);

        req(1'b1, 1'b1, 32'd1024, 32'h1234_5678, 0, 0, st, wl, fa);
        chk("t4_we_low", 32'(wl), 32'd4);
        chk("t4_hw0", 32'(sram_mem[0]), 32'h5678);
        chk("t4_hw1", 32'(sram_mem[1]), 32'h1234);
        chk("t4_rdata_kept", readData, 32'hFFFF_0000);

        req(1'b0, 1'b1, 32'd1024, 32'hDEAD_BEEF, 1, 0, st, wl, fa);
        chk("t5_stall_a", 32'(st), 32'd5);
        req(1'b0, 1'b1, 32'd1028, 32'h0BAD_F00D, 0, 0, st, wl, fa);
        chk("t5_stall_b", 32'(st), 32'd5);
        chk("t5_hw0", 32'(sram_mem[0]), 32'hBEEF);
        chk("t5_hw1", 32'(sram_mem[1]), 32'hDEAD);
        chk("t5_hw2", 32'(sram_mem[2]), 32'hF00D);
        chk("t5_hw3", 32'(sram_mem[3]), 32'h0BAD);

        req(1'b1, 1'b0, 32'd1020, 32'h0, 0, 0, st, wl, fa);
        chk("wrap_addr", 32'(fa), 32'h3FFFE);

        abort_req(1'b0, 1'b1, 32'd1424, 32'hCAFE_BABE, 4);
        chk("t6_hw_lo", 32'(sram_mem[200]), 32'hBABE);
        chk("t6_hw_hi", 32'(sram_mem[201]), 32'h0000);

        for (int i = 0; i < 300; i++) begin
            op   = int'($urandom_range(0, 9));
            hold = 1'($urandom_range(0, 1));
            a    = 32'd1024 + 32'($urandom_range(0, 255)) * 32'd4 + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 24) == 0) begin
                abort_req(1'(op <= 3 || op == 9), 1'(op >= 4), a, $urandom,
                          int'($urandom_range(1, 6)));
            end else begin
                req(1'(op <= 3 || op == 9), 1'(op >= 4), a, $urandom, hold, 1, st, wl, fa);
                if (!hold) repeat ($urandom_range(0, 2)) @(posedge clk);
            end
        end
        @(posedge clk);
        #1;
        rdEn = 1'b0; wrEn = 1'b0;
        repeat (10) @(posedge clk);

        diffs = 0;
        for (int i = 0; i < 1024; i++) if (sram_mem[i] !== ref_mem[i]) diffs++;
        chk("mem_image", 32'(diffs), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Initiator-side data-memory port for the MEM stage: accepts 32-bit word read/write requests (rdEn/wrEn, address, writeData).
- Serves each request as two 16-bit accesses on an external asynchronous SRAM: low half first, then high half.
- Holds ready low so the pipeline freezes until the access completes; returns read data on readData.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM word 0.
- SRAM_ADDR_W, 18: SRAM halfword address width.
- ACCESS_CYCLES, 2: cycles each halfword access is held on the SRAM bus (must be >= 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rdEn  in  1  read request, held by pipeline until ready=1.
- wrEn  in  1  write request, held by pipeline until ready=1.
- address  in  32  byte address.
- writeData  in  32  write word.
- readData  out  32  last completed read word.
- ready  out  1  1 = no pending access / access complete; 0 = freeze pipeline.
- sramAddr  out  SRAM_ADDR_W  SRAM halfword address.
- sramDataOut  out  16  SRAM write data.
- sramDataIn  in  16  SRAM read data.
- sramDataOE  out  1  1 = drive sramDataOut onto SRAM bus.
- sramWE_N  out  1  SRAM write enable, active low.

Behaviour:
- States: IDLE, LO, HI, DONE. A 2-bit counter `cnt` counts cycles within LO and HI.
- Address map: word = (address - BASE_ADDR) >> 2, computed as unsigned subtraction with wraparound. Bits [1:0] are ignored. The SRAM halfword address is {word[SRAM_ADDR_W-2:0], half}, with half=0 in LO and half=1 in HI. Out-of-range addresses are truncated, with no error.
- IDLE, no request: stay in IDLE; ready=1.
- IDLE, rdEn or wrEn: ready=0 combinationally. On the next edge, latch op, word and writeData, set cnt=0, go to LO.
- Simultaneous rdEn and wrEn: treated as a write.
- LO: cnt increments each cycle. When cnt=ACCESS_CYCLES-1 at the edge:
  - on a read, capture sramDataIn into readData[15:0];
  - go to HI with cnt=0.
- HI: same as LO. On exit:
  - on a read, capture sramDataIn into readData[31:16];
  - go to DONE.
- DONE: ready=1 for exactly one cycle. The next edge always goes to IDLE, even if a request is present. A request still asserted in the following IDLE cycle is a new request.
- ready is 1 in DONE and in IDLE with no request, 0 otherwise.
- Latency: from the IDLE cycle that sees a request, ready is low for 1+2*ACCESS_CYCLES cycles (5 at default). DONE follows.
- SRAM outputs depend only on state and latched request, never combinationally on request inputs:
  - LO/HI write: sramWE_N=0, sramDataOE=1, sramDataOut = latched writeData[15:0] in LO and [31:16] in HI.
  - LO/HI read: sramWE_N=1, sramDataOE=0.
  - IDLE/DONE: sramAddr=0, sramDataOut=0, sramWE_N=1, sramDataOE=0.
- readData changes only when a read completes; writes never alter it.
- Inputs changing mid-access are ignored; the latched request is used.
- Reset (async, any state): state=IDLE, cnt=0, readData=0, latched request cleared, sramAddr=0, sramDataOut=0, sramWE_N=1, sramDataOE=0. ready then follows the IDLE rule. An access interrupted by reset is abandoned; any SRAM halfword already written stays written.

Test Plan:
- Reset, then wrEn=1, address=1024, writeData=0x55555555 -> ready=0 for 5 cycles. SRAM model halfwords 0 and 1 = 0x5555, sramWE_N low for 2 cycles each. ready=1 in DONE cycle. sramWE_N=1 and sramDataOE=0 afterwards.
- Write address=1030, writeData=0xAAAAAAAA -> word 1 (low bits ignored): halfword 2=0xAAAA, 3=0xAAAA. Then rdEn at 1028 -> readData=0xAAAAAAAA in the DONE cycle.
- Preload halfword 4=0x0000 and 5=0xFFFF; rdEn address=1033 -> readData=0xFFFF0000 at DONE. A following write leaves readData unchanged.
- rdEn=1 and wrEn=1 with writeData=0x12345678 at 1024 -> treated as write: halfwords 0/1 = 0x5678/0x1234, readData unchanged.
- Hold wrEn across two back-to-back requests (addresses 1024, then 1028 presented after DONE) -> two full 5-cycle stalls with one DONE cycle each, and no request lost or duplicated.
- Assert rst during HI of a write -> state IDLE immediately, sramWE_N=1, ready = !(rdEn|wrEn), readData=0. The low halfword has already been written; the high halfword is untouched.
